// File: rtl/dram_rd_arbiter_pkg.sv
// Shared types for the DRAM read arbiter.
// FSM encodings, port ids and a grant decode helper.
package dram_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Port 1 as the reset history lets port 0 win the first contested grant.
    localparam logic RESET_LAST_GRANT = PORT1;

    function automatic logic [1:0] grant_onehot(input logic g);
        return (g == PORT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dram_rd_arbiter_if.sv
// Bundle of the two requester ports and the DRAM read channel.
// slave = arbiter view, master = surrounding system view.
interface dram_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic [ADDR_W-1:0] p0_addr;
    logic              p0_fin;
    logic [DATA_W-1:0] p0_data;

    logic              p1_req;
    logic [ADDR_W-1:0] p1_addr;
    logic              p1_fin;
    logic [DATA_W-1:0] p1_data;

    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_fin;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  p0_req, p0_addr,
        input  p1_req, p1_addr,
        input  mem_rd_fin, mem_rd_data,
        output p0_fin, p0_data,
        output p1_fin, p1_data,
        output mem_rd_req, mem_rd_addr
    );

    modport master (
        output p0_req, p0_addr,
        output p1_req, p1_addr,
        output mem_rd_fin, mem_rd_data,
        input  p0_fin, p0_data,
        input  p1_fin, p1_data,
        input  mem_rd_req, mem_rd_addr
    );

endinterface

// File: rtl/dram_rd_arbiter_rr_pick2.sv
// Combinational two-way winner select.
// Round-robin or fixed priority (port 0) when both request.
module dram_rd_arbiter_rr_pick2
    import dram_rd_arbiter_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_valid,
    output logic       o_grant
);

    always_comb begin
        o_valid = |i_req;
        o_grant = PORT0;
        unique case (i_req)
            2'b11:   o_grant = RR_ENABLE ? ~i_last_grant : PORT0;
            2'b10:   o_grant = PORT1;
            default: o_grant = PORT0;
        endcase
    end

endmodule

// File: rtl/dram_rd_arbiter.sv
// Two-port read arbiter in front of the single DRAM read channel.
// Port 0 is instruction fetch, port 1 the load unit.
module dram_rd_arbiter
    import dram_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    dram_rd_arbiter_if.slave bus
);

    state_t            r_state;
    logic              r_grant;
    logic              r_last_grant;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_p0_fin;
    logic              r_p1_fin;
    logic [DATA_W-1:0] r_p0_data;
    logic [DATA_W-1:0] r_p1_data;

    logic [1:0]        w_req;
    logic              w_valid;
    logic              w_pick;
    logic [ADDR_W-1:0] w_pick_addr;
    logic [1:0]        w_fin_sel;

    assign w_req = {bus.p1_req, bus.p0_req};

    dram_rd_arbiter_rr_pick2 #(
        .RR_ENABLE(RR_ENABLE)
    ) u_rr_pick2 (
        .i_req       (w_req),
        .i_last_grant(r_last_grant),
        .o_valid     (w_valid),
        .o_grant     (w_pick)
    );

    assign w_pick_addr = (w_pick == PORT1) ? bus.p1_addr : bus.p0_addr;
    assign w_fin_sel   = grant_onehot(r_grant);

    // DONE is a dead cycle so the requester can drop req before IDLE looks again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= PORT0;
            r_last_grant <= RESET_LAST_GRANT;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_p0_fin     <= 1'b0;
            r_p1_fin     <= 1'b0;
            r_p0_data    <= '0;
            r_p1_data    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_p0_fin <= 1'b0;
                    r_p1_fin <= 1'b0;
                    if (w_valid) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_mem_addr   <= w_pick_addr;
                        r_mem_req    <= 1'b1;
                        r_state      <= ST_BUSY;
                    end else begin
                        r_mem_req <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (bus.mem_rd_fin) begin
                        r_mem_req <= 1'b0;
                        if (w_fin_sel[0]) begin
                            r_p0_data <= bus.mem_rd_data;
                            r_p0_fin  <= 1'b1;
                        end
                        if (w_fin_sel[1]) begin
                            r_p1_data <= bus.mem_rd_data;
                            r_p1_fin  <= 1'b1;
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_p0_fin <= 1'b0;
                    r_p1_fin <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_p0_fin  <= 1'b0;
                    r_p1_fin  <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd_req  = r_mem_req;
    assign bus.mem_rd_addr = r_mem_addr;
    assign bus.p0_fin      = r_p0_fin;
    assign bus.p0_data     = r_p0_data;
    assign bus.p1_fin      = r_p1_fin;
    assign bus.p1_data     = r_p1_data;

endmodule
